sys_mem_ptr_mngr: RTL
=====================

SYS_MEM_PTR_MNGR -- requirements
Module: sys_mem_ptr_mngr

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 27, memory word-address width.
REQ-002 SHALL have parameter NUM_AGENTS, default 2, number of agents served.
REQ-003 SHALL have parameter AGENT_ID_W, default $clog2(NUM_AGENTS), derived and not overridden.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1, pointer request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when high together with req_valid.
REQ-008 SHALL have port req_agent_id, input, AGENT_ID_W, requesting agent.
REQ-009 SHALL have port req_wr, input, 1, 1 = write slot, 0 = read slot.
REQ-010 SHALL have port part_agent_id, output, AGENT_ID_W, agent index driven to the partition manager.
REQ-011 SHALL have ports part_start_addr and part_end_addr, input, MEM_ADDR_W each, inclusive partition bounds; valid one cycle after part_agent_id is stable.
REQ-012 SHALL have port rsp_valid, output, 1, response present.
REQ-013 SHALL have port rsp_ready, input, 1, response consumed.
REQ-014 SHALL have port rsp_addr, output, MEM_ADDR_W, granted word address.
REQ-015 SHALL have port rsp_status, output, 2, 00 OK, 01 FULL, 10 EMPTY, 11 BADPART.
REQ-016 SHALL have ports flush_en (input, 1) and flush_agent_id (input, AGENT_ID_W), single-cycle pointer flush.

Function
REQ-017 SHALL keep per agent: wr_ptr and rd_ptr (MEM_ADDR_W), fill (MEM_ADDR_W+1), and vld (1).
REQ-018 SHALL use an FSM IDLE -> LOOKUP -> CALC -> RESP -> IDLE.
- req_ready = 1 only in IDLE.
- A handshake in cycle N moves the FSM to LOOKUP in N+1, CALC in N+2, and RESP in N+3.
REQ-019 SHALL register req_agent_id and req_wr on handshake; part_agent_id SHALL equal the registered id at all times.
REQ-020 SHALL, in CALC, use part_start_addr/part_end_addr as sampled that cycle.
- size = end - start + 1, computed at width MEM_ADDR_W+1.
- If vld = 0, the agent is treated as wr_ptr = rd_ptr = start, fill = 0.
REQ-021 SHALL, for end < start, return BADPART with rsp_addr = 0 and leave agent state unchanged.
REQ-022 SHALL, for a write with fill == size, return FULL with rsp_addr = wr_ptr, no state change.
- Otherwise: OK, rsp_addr = wr_ptr, wr_ptr advances, fill increments, vld set.
REQ-023 SHALL, for a read with fill == 0, return EMPTY with rsp_addr = rd_ptr, no state change.
- Otherwise: OK, rsp_addr = rd_ptr, rd_ptr advances, fill decrements, vld set.
REQ-024 SHALL advance pointers as next = (ptr == end) ? start : ptr + 1 (wrap-around).
REQ-025 SHALL, in RESP, hold rsp_valid = 1 with rsp_addr/rsp_status stable until rsp_ready = 1, then return to IDLE; rsp_valid = 0 in all other states.
REQ-026 SHALL, on flush_en, clear vld and fill of flush_agent_id in the next cycle.
- If flush_en coincides with the CALC update of the same agent, the flush SHALL win.
- The in-flight response is still returned unchanged.
REQ-027 SHALL ignore flush_agent_id >= NUM_AGENTS and treat requests with req_agent_id >= NUM_AGENTS as BADPART.
REQ-028 SHALL require a flush of every affected agent after any partition reconfiguration; stale pointers are not auto-detected.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force:
- FSM = IDLE, req_ready = 1, rsp_valid = 0, rsp_addr = 0, rsp_status = 00, part_agent_id = 0
- all wr_ptr, rd_ptr and fill = 0, all vld = 0
REQ-030 SHALL abort any in-flight request on reset with no response issued; the first request after reset SHALL see vld = 0.

Verification
REQ-031 Agent 0 partition 0x100..0x103; 4 writes -> OK addrs 0x100, 0x101, 0x102, 0x103; 5th write -> FULL, rsp_addr 0x100.
REQ-032 Same partition, then 4 reads -> OK 0x100..0x103; 5th read -> EMPTY; next write -> OK 0x100 (wrap).
REQ-033 Handshake in cycle N with rsp_ready tied 1 -> rsp_valid in cycle N+3 only, req_ready high again in N+4; rsp_ready held 0 for 5 cycles -> response stable, no new accept.
REQ-034 Agent 1 start 0x200, end 0x1FF -> BADPART, rsp_addr 0; agent 0 fill unaffected.
REQ-035 flush_en for agent 0 in the same cycle as a CALC write for agent 0 -> response OK; next write for agent 0 -> OK with addr = start.
REQ-036 rst_n asserted in LOOKUP -> no rsp_valid; all outputs at reset values; first post-reset write -> addr = start.

Source files
------------

// File: rtl/sys_mem_ptr_mngr.sv
// Per-agent circular buffer pointer manager: grants write/read slot addresses
// inside partitions supplied by an external partition manager.
module sys_mem_ptr_mngr #(
    parameter int MEM_ADDR_W = 27,
    parameter int NUM_AGENTS = 2,
    parameter int AGENT_ID_W = $clog2(NUM_AGENTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AGENT_ID_W-1:0] req_agent_id,
    input  logic                  req_wr,
    output logic [AGENT_ID_W-1:0] part_agent_id,
    input  logic [MEM_ADDR_W-1:0] part_start_addr,
    input  logic [MEM_ADDR_W-1:0] part_end_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MEM_ADDR_W-1:0] rsp_addr,
    output logic [1:0]            rsp_status,
    input  logic                  flush_en,
    input  logic [AGENT_ID_W-1:0] flush_agent_id
);
    localparam int SLOTS = 1 << AGENT_ID_W;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FULL    = 2'b01;
    localparam logic [1:0] ST_EMPTY   = 2'b10;
    localparam logic [1:0] ST_BADPART = 2'b11;
    localparam logic [MEM_ADDR_W-1:0] PTR_ONE  = MEM_ADDR_W'(1);
    localparam logic [MEM_ADDR_W:0]   FILL_ONE = (MEM_ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, LOOKUP, CALC, RESP} state_t;
    state_t state;

    logic [MEM_ADDR_W-1:0] wr_ptr [SLOTS];
    logic [MEM_ADDR_W-1:0] rd_ptr [SLOTS];
    logic [MEM_ADDR_W:0]   fill   [SLOTS];
    logic [SLOTS-1:0]      vld;
    logic [SLOTS-1:0]      id_ok;
    logic                  req_wr_q;

    // Slots past NUM_AGENTS exist only to keep indexing total; they are never updated.
    for (genvar g = 0; g < SLOTS; g++) begin : g_id_ok
        assign id_ok[g] = (g < NUM_AGENTS);
    end

    logic                  cur_vld;
    logic [MEM_ADDR_W-1:0] cur_wr, cur_rd, nxt_wr, nxt_rd;
    logic [MEM_ADDR_W:0]   cur_fill, size;
    logic                  bad_part;

    always_comb begin
        cur_vld  = vld[part_agent_id];
        cur_wr   = cur_vld ? wr_ptr[part_agent_id] : part_start_addr;
        cur_rd   = cur_vld ? rd_ptr[part_agent_id] : part_start_addr;
        cur_fill = cur_vld ? fill[part_agent_id] : '0;
        size     = {1'b0, part_end_addr} - {1'b0, part_start_addr} + FILL_ONE;
        bad_part = (part_end_addr < part_start_addr) || !id_ok[part_agent_id];
        nxt_wr   = (cur_wr == part_end_addr) ? part_start_addr : cur_wr + PTR_ONE;
        nxt_rd   = (cur_rd == part_end_addr) ? part_start_addr : cur_rd + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_addr      <= '0;
            rsp_status    <= ST_OK;
            part_agent_id <= '0;
            req_wr_q      <= 1'b0;
            vld           <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fill[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        part_agent_id <= req_agent_id;
                        req_wr_q      <= req_wr;
                        req_ready     <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                // Partition bounds for part_agent_id become valid in the following cycle.
                LOOKUP: state <= CALC;
                CALC: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    if (bad_part) begin
                        rsp_status <= ST_BADPART;
                        rsp_addr   <= '0;
                    end else if (req_wr_q) begin
                        rsp_addr <= cur_wr;
                        if (cur_fill == size) begin
                            rsp_status <= ST_FULL;
                        end else begin
                            rsp_status            <= ST_OK;
                            wr_ptr[part_agent_id] <= nxt_wr;
                            rd_ptr[part_agent_id] <= cur_rd;
                            fill[part_agent_id]   <= cur_fill + FILL_ONE;
                            vld[part_agent_id]    <= 1'b1;
                        end
                    end else begin
                        rsp_addr <= cur_rd;
                        if (cur_fill == '0) begin
                            rsp_status <= ST_EMPTY;
                        end else begin
                            rsp_status            <= ST_OK;
                            rd_ptr[part_agent_id] <= nxt_rd;
                            wr_ptr[part_agent_id] <= cur_wr;
                            fill[part_agent_id]   <= cur_fill - FILL_ONE;
                            vld[part_agent_id]    <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a flush overrides a same-cycle CALC update of the same agent.
            if (flush_en && id_ok[flush_agent_id]) begin
                vld[flush_agent_id]  <= 1'b0;
                fill[flush_agent_id] <= '0;
            end
        end
    end
endmodule
